// File: rtl/seq_booth_mult.sv
// Iterative signed WIDTHxWIDTH radix-2 Booth multiplier, one multiplier bit per clock.
// Debug mirrors (ctest/acctest/multest) are driven only when SEQ_MULT_DEBUG_EN is defined.
module seq_booth_mult #(
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    input  logic [4:0]                 ctrl,
    output logic [WIDTH-1:0]           lower,
    output logic [WIDTH-1:0]           higher,
    output logic [$clog2(WIDTH)-1:0]   ctest,
    output logic [WIDTH-1:0]           acctest,
    output logic [WIDTH-1:0]           multest,
    output logic                       in,
    output logic                       out
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH:0]   acc_q;
    logic [WIDTH:0]   m_q;
    logic [WIDTH-1:0] mreg_q;
    logic             q1_q;
    logic [WIDTH-1:0] lower_q;
    logic [WIDTH-1:0] higher_q;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   acc_d;
    logic [WIDTH-1:0] mreg_d;
    logic             q1_d;

    logic hold;
    logic restart;
    logic unused_ctrl;

    assign hold        = ctrl[0];
    assign restart     = ctrl[1];
    assign unused_ctrl = ^ctrl[4:2];

    // One Booth step: add/sub M into the 33-bit accumulator, then arithmetic shift {acc,mreg,q_1}.
    always_comb begin
        sum = acc_q;
        case ({mreg_q[0], q1_q})
            2'b01:   sum = acc_q + m_q;
            2'b10:   sum = acc_q - m_q;
            default: sum = acc_q;
        endcase
        acc_d  = {sum[WIDTH], sum[WIDTH:1]};
        mreg_d = {sum[0], mreg_q[WIDTH-1:1]};
        q1_d   = mreg_q[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= LOAD;
            count_q  <= '0;
            acc_q    <= '0;
            m_q      <= '0;
            mreg_q   <= '0;
            q1_q     <= 1'b0;
            lower_q  <= '0;
            higher_q <= '0;
        end else if (!hold) begin
            if (restart) begin
                state_q <= LOAD;
                count_q <= '0;
            end else begin
                case (state_q)
                    LOAD: begin
                        m_q     <= {a[WIDTH-1], a};
                        mreg_q  <= b;
                        acc_q   <= '0;
                        q1_q    <= 1'b0;
                        count_q <= '0;
                        state_q <= RUN;
                    end
                    RUN: begin
                        acc_q  <= acc_d;
                        mreg_q <= mreg_d;
                        q1_q   <= q1_d;
                        if (count_q == CW'(WIDTH - 1)) begin
                            state_q <= DONE;
                        end else begin
                            count_q <= count_q + CW'(1);
                        end
                    end
                    DONE: begin
                        lower_q  <= mreg_q;
                        higher_q <= acc_q[WIDTH-1:0];
                        state_q  <= LOAD;
                    end
                    default: state_q <= LOAD;
                endcase
            end
        end
    end

    assign lower  = lower_q;
    assign higher = higher_q;
    assign in     = (state_q == LOAD);
    assign out    = (state_q == DONE);

`ifdef SEQ_MULT_DEBUG_EN
    assign ctest   = count_q;
    assign acctest = acc_q[WIDTH-1:0];
    assign multest = mreg_q;
`else
    assign ctest   = '0;
    assign acctest = '0;
    assign multest = '0;
`endif

endmodule

// File: tb/tb_seq_booth_mult.sv
// Directed bench for seq_booth_mult: product table, latency, hold, restart and mid-run reset.
module tb_seq_booth_mult;
    logic        clk;
    logic        rst;
    logic [31:0] a_r;
    logic [31:0] b_r;
    logic [4:0]  ctrl;
    logic [31:0] lower;
    logic [31:0] higher;
    logic [4:0]  ctest;
    logic [31:0] acctest;
    logic [31:0] multest;
    logic        dut_in;
    logic        dut_out;

`ifdef SEQ_MULT_DEBUG_EN
    localparam bit DBG = 1'b1;
`else
    localparam bit DBG = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    seq_booth_mult #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a_r),
        .b       (b_r),
        .ctrl    (ctrl),
        .lower   (lower),
        .higher  (higher),
        .ctest   (ctest),
        .acctest (acctest),
        .multest (multest),
        .in      (dut_in),
        .out     (dut_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] prod;
    } vec_t;

    vec_t vecs[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Steps until out is seen (bounded); n is the 1-based cycle index counting the LOAD cycle as 1.
    task automatic wait_out(input int n0, output int n);
        n = n0;
        while (!dut_out && n < 200) begin
            step();
            n++;
        end
    endtask

    task automatic run_vec(input string nm, input logic [31:0] av, input logic [31:0] bv,
                           input logic [63:0] exp);
        int n;
        chk({nm, " in_at_start"}, 64'(dut_in), 64'd1);
        a_r = av;
        b_r = bv;
        wait_out(1, n);
        chk({nm, " latency"}, 64'(n), 64'd34);
        step();
        chk({nm, " out_one_cycle"}, 64'(dut_out), 64'd0);
        chk({nm, " product"}, {higher, lower}, exp);
    endtask

    initial begin
        int n;
        logic [4:0]  c_snap;
        logic [31:0] acc_snap;
        logic [31:0] mul_snap;

        vecs[0] = '{32'd16,        32'd3,        64'h0000_0000_0000_0030};
        vecs[1] = '{-32'sd7,       32'd6,        64'hFFFF_FFFF_FFFF_FFD6};
        vecs[2] = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        vecs[3] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0001};
        vecs[4] = '{32'd12345,     -32'sd678,    64'hFFFF_FFFF_FF80_490A};
        vecs[5] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001};
        vecs[6] = '{32'h8000_0000, 32'd1,        64'hFFFF_FFFF_8000_0000};
        vecs[7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001};

        rst  = 1'b1;
        ctrl = 5'd0;
        a_r  = 32'd0;
        b_r  = 32'd0;
        step();
        step();
        chk("reset product", {higher, lower}, 64'd0);
        chk("reset in", 64'(dut_in), 64'd1);
        chk("reset out", 64'(dut_out), 64'd0);
        chk("reset ctest", 64'(ctest), 64'd0);
        chk("reset acctest", 64'(acctest), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].prod);
        end

        // Hold for 5 cycles once count reaches 10: everything freezes, out is delayed by 5.
        a_r = 32'd100;
        b_r = -32'sd5;
        n = 1;
        for (int k = 0; k < 11; k++) begin
            step();
            n++;
        end
        chk("hold pre ctest", 64'(ctest), DBG ? 64'd10 : 64'd0);
        c_snap   = ctest;
        acc_snap = acctest;
        mul_snap = multest;
        ctrl = 5'd1;
        for (int k = 0; k < 5; k++) begin
            step();
            n++;
            chk("hold out", 64'(dut_out), 64'd0);
        end
        chk("hold ctest", 64'(ctest), 64'(c_snap));
        chk("hold acctest", 64'(acctest), 64'(acc_snap));
        chk("hold multest", 64'(multest), 64'(mul_snap));
        ctrl = 5'd0;
        wait_out(n, n);
        chk("hold latency", 64'(n), 64'd39);
        step();
        chk("hold product", {higher, lower}, 64'hFFFF_FFFF_FFFF_FE0C);

        // Restart at count 20: back to LOAD at once, old product retained.
        a_r = 32'd9;
        b_r = 32'd9;
        for (int k = 0; k < 21; k++) step();
        chk("restart pre ctest", 64'(ctest), DBG ? 64'd20 : 64'd0);
        ctrl = 5'd2;
        step();
        ctrl = 5'd0;
        chk("restart in", 64'(dut_in), 64'd1);
        chk("restart ctest", 64'(ctest), 64'd0);
        chk("restart keeps product", {higher, lower}, 64'hFFFF_FFFF_FFFF_FE0C);
        run_vec("after_restart", 32'd3, -32'sd4, 64'hFFFF_FFFF_FFFF_FFF4);

        // Reset in the middle of RUN clears everything.
        a_r = 32'd5;
        b_r = 32'd5;
        for (int k = 0; k < 10; k++) step();
        rst = 1'b1;
        step();
        chk("midrst product", {higher, lower}, 64'd0);
        chk("midrst in", 64'(dut_in), 64'd1);
        chk("midrst out", 64'(dut_out), 64'd0);
        chk("midrst ctest", 64'(ctest), 64'd0);
        chk("midrst acctest", 64'(acctest), 64'd0);
        chk("midrst multest", 64'(multest), 64'd0);
        rst = 1'b0;
        run_vec("after_reset", 32'd2, 32'd3, 64'd6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seq_booth_mult.md
Name: seq_booth_mult

Overview:
- Iterative 32x32 signed multiplier using radix-2 Booth recoding, one multiplier bit per clock; produces a 64-bit two's-complement product split into `lower`/`higher` words.
- Free-running: reloads operands automatically after each result unless held.
- Datapath utility block; internal state visible on debug ports for bring-up.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH. Counter width is clog2(WIDTH) = 5 at default.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; one clock; reset is synchronous and active-high
- a  input  32  signed multiplicand, sampled in LOAD
- b  input  32  signed multiplier, sampled in LOAD
- ctrl  input  5  control:
  - bit0 = hold (freeze all state)
  - bit1 = restart (force LOAD next cycle)
  - bits4:2 reserved, ignored
- lower  output  32  product bits [31:0], registered
- higher  output  32  product bits [63:32], registered
- ctest  output  5  iteration counter
- acctest  output  32  accumulator bits [31:0]
- multest  output  32  multiplier/low shift register
- in  output  1  high while in LOAD state (operands being sampled)
- out  output  1  high for exactly one cycle in DONE (`lower`/`higher` just updated)

Behaviour:
- Reset (rst=1 at posedge):
  - state=LOAD, count=0, acc=0, mreg=0, q_1=0, M=0.
  - lower=0, higher=0, in=1, out=0.
  - Reset wins over hold and restart.
- State LOAD (in=1), at posedge:
  - M <= sign-extended a (33 bits); mreg <= b; acc <= 0; q_1 <= 0; count <= 0.
  - Go to RUN.
- State RUN, each posedge:
  - Examine {mreg[0], q_1}:
    - 01: acc = acc + M
    - 10: acc = acc - M
    - 00/11: no change
  - Then arithmetic right shift of {acc(33b), mreg, q_1} by 1. Sign bit = acc[32] after add/sub.
  - count increments.
  - After the step taken with count==31: go to DONE (exactly 32 RUN cycles); count stays at 31.
- State DONE (out=1), at posedge:
  - lower <= mreg; higher <= acc[31:0].
  - Go to LOAD.
  - `out` is a combinational decode of state==DONE. The product registers therefore update on the DONE→LOAD edge, and are valid from the cycle after out=1 until the next DONE edge.
- Accumulator is 33 bits internally so M = -2^31 does not overflow. The product is exact for all inputs, including (-2^31)*(-2^31) = 2^62.
- Latency: LOAD edge + 32 RUN edges + DONE edge = 34 clocks from first LOAD cycle to updated `lower`/`higher`; throughput one product per 34 cycles.
- Operands change mid-operation: ignored until next LOAD.
- ctrl[0]=1: no register changes (outputs frozen); resumes exactly where stopped.
- ctrl[1]=1 (and hold=0): next state forced to LOAD from any state. Current operation is aborted; `lower`/`higher` keep their previous value.
- If hold and restart are both set, hold wins.
- `in` = (state==LOAD).
- `ctest`, `acctest`, `multest` mirror count, acc[31:0], mreg.

Optional Feature:
- Macro SEQ_MULT_DEBUG_EN.
- Defined: ctest/acctest/multest/in/out driven as above.
- Not defined: ctest, acctest and multest tied to 0; in and out still driven (functional handshake).
- Ports present in both builds.

Test Plan:
- rst=1 for 2 cycles, then release with a=16, b=3, ctrl=0:
  - in=1 first cycle; out=1 in cycle 34.
  - Afterwards {higher,lower} = 0x0000000000000030 (48).
- a=-7, b=6 -> {higher,lower} = 0xFFFFFFFFFFFFFFD6 (-42).
- a=-2147483648, b=-2147483648 -> 0x4000000000000000.
- a=0x7FFFFFFF, b=-1 -> 0xFFFFFFFF80000001.
- ctrl=1 asserted 5 cycles at count=10:
  - ctest/acctest/multest frozen.
  - out arrives 5 cycles later than without hold; product unchanged.
- ctrl=2 pulsed at count=20:
  - next cycle in=1, count=0.
  - lower/higher keep the prior product.
  - Assert rst mid-RUN -> next cycle all outputs 0, in=1.
